// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter slice.
//   ALU_ARB_DW / ALU_ARB_FW : default operand/result and function-select widths
//   SREG_W                  : width of the ALU status nibble
//   arb_state_t             : arbiter FSM encoding (IDLE, EXEC, RESP)
//   next_rr_ptr()           : pointer value after a grant (points at the loser)
// ---------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int ALU_ARB_DW = 8;
   localparam int ALU_ARB_FW = 4;
   localparam int SREG_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   // After granting req0 the pointer moves to req1 and vice versa, so the
   // requester that just lost gets first pick on the next contention.
   function automatic logic next_rr_ptr(input logic [1:0] grant);
      return grant[0];
   endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// ---------------------------------------------------------------------------
// alu_rr_pick
// Combinational grant selection for two requesters.
//   valid0, valid1 : request valids
//   rr_ptr         : round-robin pointer (0 = req0 preferred, 1 = req1)
//   fixed_mode     : 1 = req0 always wins on contention, pointer ignored
//   grant[1:0]     : one-hot grant, all zero when nobody is requesting
// ---------------------------------------------------------------------------
module alu_rr_pick (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       rr_ptr,
   input  logic       fixed_mode,
   output logic [1:0] grant
);

   // A lone requester always wins; contention is settled by the pointer
   // unless fixed priority is selected.
   always_comb begin
      grant = 2'b00;
      if (valid0 && valid1) begin
         grant = (fixed_mode || !rr_ptr) ? 2'b01 : 2'b10;
      end else if (valid0) begin
         grant = 2'b01;
      end else if (valid1) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. A granted request is
// latched, presented to the ALU for one cycle (EXEC), and the ALU result is
// registered and held as a response until it is accepted (RESP).
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins
// every contention); otherwise requesters alternate round-robin.
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   reqN_valid/ready           : request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_fsel  : operands and function select
//   resp_valid/ready           : response handshake
//   resp_id                    : which requester the response belongs to
//   resp_result/high/sreg      : captured ALU result, high half, status
//   alu_a, alu_b, alu_fsel     : operands to the shared ALU
//   alu_out, alu_high, alu_sreg: results from the shared ALU
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DW = ALU_ARB_DW,
   parameter int FW = ALU_ARB_FW
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DW-1:0]     req0_a,
   input  logic [DW-1:0]     req0_b,
   input  logic [FW-1:0]     req0_fsel,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DW-1:0]     req1_a,
   input  logic [DW-1:0]     req1_b,
   input  logic [FW-1:0]     req1_fsel,

   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DW-1:0]     resp_result,
   output logic [DW-1:0]     resp_high,
   output logic [SREG_W-1:0] resp_sreg,

   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [FW-1:0]     alu_fsel,
   input  logic [DW-1:0]     alu_out,
   input  logic [DW-1:0]     alu_high,
   input  logic [SREG_W-1:0] alu_sreg
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam logic FIXED_MODE = 1'b1;
`else
   localparam logic FIXED_MODE = 1'b0;
`endif

   arb_state_t        state;
   arb_state_t        next_state;
   logic              rr_ptr;
   logic [1:0]        grant;
   logic              accept;
   logic [DW-1:0]     lat_a;
   logic [DW-1:0]     lat_b;
   logic [FW-1:0]     lat_fsel;
   logic              lat_id;

   alu_rr_pick u_pick (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .rr_ptr     (rr_ptr),
      .fixed_mode (FIXED_MODE),
      .grant      (grant)
   );

   // A transfer happens exactly when one of the two readies is up.
   assign accept = req0_ready | req1_ready;

   // The ALU always sees the most recently latched request, so its inputs
   // hold steady between operations instead of dropping back to zero.
   assign alu_a    = lat_a;
   assign alu_b    = lat_b;
   assign alu_fsel = lat_fsel;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one cycle in EXEC, then wait in RESP for the consumer.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept)     next_state = ST_EXEC;
         ST_EXEC:                 next_state = ST_RESP;
         ST_RESP: if (resp_ready) next_state = ST_IDLE;
         default:                 next_state = ST_IDLE;
      endcase
   end

   // Output logic. Readies are masked while reset is held so nothing looks
   // acceptable during reset even though the state register reads IDLE.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      if (state == ST_IDLE && !reset) begin
         req0_ready = grant[0];
         req1_ready = grant[1];
      end
      if (state == ST_RESP) begin
         resp_valid = 1'b1;
      end
   end

   // Request latches, round-robin pointer and response registers. The
   // response is captured at the end of EXEC and left untouched through RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr      <= 1'b0;
         lat_a       <= '0;
         lat_b       <= '0;
         lat_fsel    <= '0;
         lat_id      <= 1'b0;
         resp_id     <= 1'b0;
         resp_result <= '0;
         resp_high   <= '0;
         resp_sreg   <= '0;
      end else begin
         if (accept) begin
            lat_a    <= grant[1] ? req1_a    : req0_a;
            lat_b    <= grant[1] ? req1_b    : req0_b;
            lat_fsel <= grant[1] ? req1_fsel : req0_fsel;
            lat_id   <= grant[1];
            rr_ptr   <= next_rr_ptr(grant);
         end
         if (state == ST_EXEC) begin
            resp_id     <= lat_id;
            resp_result <= alu_out;
            resp_high   <= alu_high;
            resp_sreg   <= alu_sreg;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with a behavioural reference ALU and a
// response scoreboard. Define ALU_ARB_FIXED_PRIO_EN for the fixed-priority
// build.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int DW = 8;
   localparam int FW = 4;

   logic          clk;
   logic          reset;
   logic          req0_valid, req0_ready;
   logic [DW-1:0] req0_a, req0_b;
   logic [FW-1:0] req0_fsel;
   logic          req1_valid, req1_ready;
   logic [DW-1:0] req1_a, req1_b;
   logic [FW-1:0] req1_fsel;
   logic          resp_valid, resp_ready, resp_id;
   logic [DW-1:0] resp_result, resp_high;
   logic [3:0]    resp_sreg;
   logic [DW-1:0] alu_a, alu_b, alu_out, alu_high;
   logic [FW-1:0] alu_fsel;
   logic [3:0]    alu_sreg;

   int test_count = 0;
   int fail_count = 0;

   typedef struct {
      logic          id;
      logic [DW-1:0] result;
      logic [DW-1:0] high;
      logic [3:0]    sreg;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_head;

   alu_arbiter #(.DW(DW), .FW(FW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_fsel   (req0_fsel),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_fsel   (req1_fsel),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_high   (resp_high),
      .resp_sreg   (resp_sreg),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_fsel    (alu_fsel),
      .alu_out     (alu_out),
      .alu_high    (alu_high),
      .alu_sreg    (alu_sreg)
   );

   // Reference ALU, packed as {high, out, sreg}; sreg = {zero, neg, high!=0, undefined}.
   function automatic logic [2*DW+3:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [FW-1:0] f);
      logic [2*DW-1:0] wide;
      logic [DW-1:0]   o;
      logic [DW-1:0]   h;
      logic            undef;
      wide  = '0;
      o     = '0;
      h     = '0;
      undef = 1'b0;
      case (f)
         4'd0: begin
            wide = {{DW{1'b0}}, a} + {{DW{1'b0}}, b};
            o    = wide[DW-1:0];
            h    = {{(DW-1){1'b0}}, wide[DW]};
         end
         4'd1: begin
            wide = {{DW{1'b0}}, a} - {{DW{1'b0}}, b};
            o    = wide[DW-1:0];
            h    = {{(DW-1){1'b0}}, wide[DW]};
         end
         4'd2: o = a & b;
         4'd3: o = a | b;
         4'd4: o = a ^ b;
         4'd5: begin
            wide = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            o    = wide[DW-1:0];
            h    = wide[2*DW-1:DW];
         end
         4'd6: begin
            wide = {{DW{1'b0}}, a} << b[2:0];
            o    = wide[DW-1:0];
            h    = wide[2*DW-1:DW];
         end
         4'd14: begin
            o = b;
            h = a;
         end
         default: undef = 1'b1;
      endcase
      return {h, o, (o == '0), o[DW-1], (h != '0), undef};
   endfunction

   function automatic logic [DW-1:0] exp_out(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [FW-1:0] f);
      logic [2*DW+3:0] r;
      r = ref_alu(a, b, f);
      return r[DW+3:4];
   endfunction

   function automatic logic [DW-1:0] exp_high(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [FW-1:0] f);
      logic [2*DW+3:0] r;
      r = ref_alu(a, b, f);
      return r[2*DW+3:DW+4];
   endfunction

   function automatic logic [3:0] exp_sreg(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [FW-1:0] f);
      logic [2*DW+3:0] r;
      r = ref_alu(a, b, f);
      return r[3:0];
   endfunction

   assign {alu_high, alu_out, alu_sreg} = ref_alu(alu_a, alu_b, alu_fsel);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                                input logic [FW-1:0] f0,
                                input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                                input logic [FW-1:0] f1);
      req0_valid = v0;
      req0_a     = a0;
      req0_b     = b0;
      req0_fsel  = f0;
      req1_valid = v1;
      req1_a     = a1;
      req1_b     = b1;
      req1_fsel  = f1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      resp_ready = 1'b1;
      repeat (3) next_cycle();
   endtask

   task automatic push_exp(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [FW-1:0] f);
      exp_t e;
      e.id     = id;
      e.result = exp_out(a, b, f);
      e.high   = exp_high(a, b, f);
      e.sreg   = exp_sreg(a, b, f);
      sb_q.push_back(e);
   endtask

   // Scoreboard: expectations are pushed on each accepted request and popped
   // on each accepted response; a reset discards whatever was in flight.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (req0_valid && req0_ready) push_exp(1'b0, req0_a, req0_b, req0_fsel);
         if (req1_valid && req1_ready) push_exp(1'b1, req1_a, req1_b, req1_fsel);
         if (resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
               checkOutput("sb_unexpected_resp", 32'd1, 32'd0);
            end else begin
               sb_head = sb_q.pop_front();
               checkOutput("sb_id",     {31'd0, resp_id},  {31'd0, sb_head.id});
               checkOutput("sb_result", {24'd0, resp_result}, {24'd0, sb_head.result});
               checkOutput("sb_high",   {24'd0, resp_high},   {24'd0, sb_head.high});
               checkOutput("sb_sreg",   {28'd0, resp_sreg},   {28'd0, sb_head.sreg});
            end
         end
      end
   end

   initial begin
      // Reset with both requesters already valid.
      reset      = 1'b1;
      resp_ready = 1'b0;
      applyStimulus(1, 127, 125, 3, 1, 1, 2, 4);
      @(negedge clk);
      checkOutput("rst_req0_ready", req0_ready, 0);
      checkOutput("rst_req1_ready", req1_ready, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_id", resp_id, 0);
      checkOutput("rst_resp_result", resp_result, 0);
      checkOutput("rst_resp_high", resp_high, 0);
      checkOutput("rst_resp_sreg", resp_sreg, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_alu_b", alu_b, 0);
      checkOutput("rst_alu_fsel", alu_fsel, 0);
      @(posedge clk);
      #1;
      reset      = 1'b0;
      resp_ready = 1'b1;

      // Contention from reset: req0 first.
      @(negedge clk);
      checkOutput("arb_c0_req0_ready", req0_ready, 1);
      checkOutput("arb_c0_req1_ready", req1_ready, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("arb_c1_alu_a", alu_a, 127);
      checkOutput("arb_c1_alu_b", alu_b, 125);
      checkOutput("arb_c1_alu_fsel", alu_fsel, 3);
      checkOutput("arb_c1_ready", {req1_ready, req0_ready}, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("arb_c2_resp_valid", resp_valid, 1);
      checkOutput("arb_c2_resp_id", resp_id, 0);
      next_cycle();
      @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
      checkOutput("fixed_c3_req0_ready", req0_ready, 1);
      checkOutput("fixed_c3_req1_ready", req1_ready, 0);
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         @(negedge clk);
         checkOutput("fixed_req1_never", req1_ready, 0);
      end
      settle();
`else
      checkOutput("rr_c3_req1_ready", req1_ready, 1);
      checkOutput("rr_c3_req0_ready", req0_ready, 0);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rr_c4_alu_a", alu_a, 1);
      next_cycle();
      @(negedge clk);
      checkOutput("rr_c5_resp_valid", resp_valid, 1);
      checkOutput("rr_c5_resp_id", resp_id, 1);
      settle();
`endif

      // Single request: (6,9,1) with resp_ready high.
      applyStimulus(1, 6, 9, 1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("basic_c0_req0_ready", req0_ready, 1);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("basic_c1_alu_a", alu_a, 6);
      checkOutput("basic_c1_alu_b", alu_b, 9);
      checkOutput("basic_c1_alu_fsel", alu_fsel, 1);
      checkOutput("basic_c1_resp_valid", resp_valid, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("basic_c2_resp_valid", resp_valid, 1);
      checkOutput("basic_c2_resp_id", resp_id, 0);
      checkOutput("basic_c2_result", resp_result, exp_out(6, 9, 1));
      checkOutput("basic_c2_high", resp_high, exp_high(6, 9, 1));
      checkOutput("basic_c2_sreg", resp_sreg, exp_sreg(6, 9, 1));
      settle();

      // Back-pressure: resp_ready low for 5 cycles; req1 requests then withdraws.
      resp_ready = 1'b0;
      applyStimulus(1, 200, 100, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("bp_c0_req0_ready", req0_ready, 1);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 1, 3, 4, 2);
      @(negedge clk);
      checkOutput("bp_c1_ready", {req1_ready, req0_ready}, 0);
      next_cycle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_hold_valid", resp_valid, 1);
         checkOutput("bp_hold_id", resp_id, 0);
         checkOutput("bp_hold_result", resp_result, exp_out(200, 100, 0));
         checkOutput("bp_hold_high", resp_high, exp_high(200, 100, 0));
         checkOutput("bp_hold_sreg", resp_sreg, exp_sreg(200, 100, 0));
         checkOutput("bp_hold_ready", {req1_ready, req0_ready}, 0);
         next_cycle();
         if (i == 2) applyStimulus(1, 9, 3, 1, 0, 0, 0, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_valid", resp_valid, 1);
      checkOutput("bp_release_ready", {req1_ready, req0_ready}, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("bp_regrant_req0", req0_ready, 1);
      checkOutput("bp_regrant_req1", req1_ready, 0);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("bp_second_valid", resp_valid, 1);
      checkOutput("bp_second_result", resp_result, exp_out(9, 3, 1));
      settle();

      // Reset during EXEC of (13,85,6).
      applyStimulus(1, 13, 85, 6, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rstx_c0_req0_ready", req0_ready, 1);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rstx_c1_alu_a", alu_a, 13);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("rstx_resp_valid", resp_valid, 0);
      checkOutput("rstx_resp_result", resp_result, 0);
      checkOutput("rstx_resp_high", resp_high, 0);
      checkOutput("rstx_resp_sreg", resp_sreg, 0);
      checkOutput("rstx_resp_id", resp_id, 0);
      checkOutput("rstx_alu_a", alu_a, 0);
      checkOutput("rstx_alu_b", alu_b, 0);
      checkOutput("rstx_alu_fsel", alu_fsel, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("rstx_no_resp", resp_valid, 0);
         next_cycle();
      end
      applyStimulus(1, 5, 5, 5, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rstx_next_ready", req0_ready, 1);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("rstx_next_valid", resp_valid, 1);
      checkOutput("rstx_next_result", resp_result, exp_out(5, 5, 5));
      settle();

      // req1 with fsel 14, then undefined encoding 15.
      applyStimulus(0, 0, 0, 0, 1, 127, 253, 14);
      @(negedge clk);
      checkOutput("fsel_c0_req1_ready", req1_ready, 1);
      checkOutput("fsel_c0_req0_ready", req0_ready, 0);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 1, 5, 5, 15);
      @(negedge clk);
      checkOutput("fsel_c1_alu_fsel", alu_fsel, 14);
      checkOutput("fsel_c1_alu_a", alu_a, 127);
      checkOutput("fsel_c1_alu_b", alu_b, 253);
      next_cycle();
      @(negedge clk);
      checkOutput("fsel_c2_resp_valid", resp_valid, 1);
      checkOutput("fsel_c2_resp_id", resp_id, 1);
      checkOutput("fsel_c2_high", resp_high, 127);
      next_cycle();
      @(negedge clk);
      checkOutput("fsel_c3_req1_ready", req1_ready, 1);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("fsel_c4_alu_fsel", alu_fsel, 15);
      checkOutput("fsel_c4_alu_a", alu_a, 5);
      next_cycle();
      @(negedge clk);
      checkOutput("fsel_c5_resp_valid", resp_valid, 1);
      checkOutput("fsel_c5_resp_id", resp_id, 1);
      checkOutput("fsel_c5_alu_fsel_hold", alu_fsel, 15);
      settle();

      checkOutput("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, meaning ALU operand/result width.
REQ-002 SHALL have parameter FW, default 4, meaning ALU function-select width.
REQ-003 SHALL have the port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have the port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have the ports reqN_valid  input  1, reqN_ready  output  1, reqN_a  input  DW, reqN_b  input  DW, reqN_fsel  input  FW, for N = 0,1 (two requesters).
REQ-006 SHALL have the ports resp_valid  output  1, resp_ready  input  1, resp_id  output  1, resp_result  output  DW, resp_high  output  DW, resp_sreg  output  4.
REQ-007 SHALL have the ports alu_a  output  DW, alu_b  output  DW, alu_fsel  output  FW, alu_out  input  DW, alu_high  input  DW, alu_sreg  input  4 (shared combinational ALU).

Function
REQ-008 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-009 SHALL assert reqN_ready only in IDLE, and only for the requester granted that cycle (at most one ready per cycle).
REQ-010 SHALL, in IDLE with one valid requester, grant it; with both valid, grant the one indicated by the round-robin pointer.
REQ-011 SHALL toggle the round-robin pointer to the non-granted requester on every accepted transfer (valid & ready).
REQ-012 SHALL, on acceptance in cycle N, latch operands, fsel and id, and enter EXEC in N+1 driving alu_a/alu_b/alu_fsel from the latches.
REQ-013 SHALL, at the end of EXEC, capture alu_out, alu_high and alu_sreg into resp registers and enter RESP; resp_valid is high from cycle N+2.
REQ-014 SHALL hold resp_valid and all resp_* fields stable until resp_ready is sampled high, then return to IDLE in the next cycle.
REQ-015 SHALL drive alu_a, alu_b and alu_fsel to the last latched values outside EXEC (no glitching to zero).
REQ-016 SHALL pass fsel through unchanged, including encodings the ALU does not define.
REQ-017 SHALL allow a requester to drop valid before being granted with no side effects.
REQ-018 SHALL give a minimum of 3 cycles between back-to-back acceptances (IDLE→EXEC→RESP→IDLE with resp_ready held high).

Reset
REQ-019 SHALL on reset force IDLE, pointer=0, resp_valid=0, reqN_ready=0, resp_id=0, and resp_result, resp_high, resp_sreg, alu_a, alu_b, alu_fsel all zero.
REQ-020 SHALL on reset mid-operation (EXEC or RESP) discard the in-flight operation; no response is ever produced for it.

Configuration
REQ-021 SHALL, with macro ALU_ARB_FIXED_PRIO_EN defined, use fixed priority (req0 always wins on contention, pointer unused); without it, use round-robin per REQ-010/011.

Structure
REQ-022 SHALL place the FSM state encoding and default DW/FW constants in shared package alu_arb_pkg.
REQ-023 SHALL implement grant selection in one sub-module alu_rr_pick (inputs: two valids, pointer, mode; output: one-hot grant).

Verification
REQ-024 SHALL verify: req0 A=6,B=9,fsel=1, resp_ready=1 → req0_ready in cycle 0, resp_valid in cycle 2 with resp_id=0 and resp_result/high/sreg equal to the reference ALU for (6,9,1).
REQ-025 SHALL verify: req0 (127,125,3) and req1 (1,2,4) both valid from reset → req0 granted first, req1 second; with ALU_ARB_FIXED_PRIO_EN and req0 continuously valid, req1 is never granted.
REQ-026 SHALL verify: resp_ready held low 5 cycles after resp_valid → all resp_* stable, both reqN_ready low throughout, new grant 1 cycle after resp_ready rises.
REQ-027 SHALL verify: reset asserted during EXEC of (13,85,6) → resp_valid stays 0, all outputs zero, next request (5,5,5) served normally.
REQ-028 SHALL verify: req1 (127,-3,14) with fsel=15 undefined-encoding follow-up (5,5,15) → alu_fsel shows 14 then 15 unchanged, responses carry resp_id=1.
